// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, error codes,
// FSM state encoding and the access legality check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  // Priority is illegal > misaligned > out of range; hi_set flags address bits beyond the memory.
  function automatic logic [1:0] access_err(input logic       we,
                                            input logic [2:0] f3,
                                            input logic [1:0] lo,
                                            input logic       hi_set);
    logic legal;
    logic half;
    logic word;
    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
            (!we && ((f3 == F3_BU) || (f3 == F3_HU)));
    half  = (f3 == F3_H) || (f3 == F3_HU);
    word  = (f3 == F3_W);
    if (!legal)                                   return ERR_ILLEGAL;
    if ((half && lo[0]) || (word && lo != 2'b00)) return ERR_MISALIGN;
    if (hi_set)                                   return ERR_RANGE;
    return ERR_OK;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: extracts and extends load data, and merges
// sub-word store data into a previously read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_word,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merge
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_word[{i_lane, 3'b000} +: 8];
    w_half = i_lane[1] ? i_word[31:16] : i_word[15:0];

    o_load = i_word;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'h0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'h0, w_half};
      default: o_load = i_word;
    endcase

    // Full-word stores bypass the read word entirely.
    o_merge = i_word;
    case (i_funct3)
      F3_B:    o_merge[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      F3_H: begin
        if (i_lane[1]) o_merge[31:16] = i_wdata[15:0];
        else           o_merge[15:0]  = i_wdata[15:0];
      end
      default: o_merge = i_wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store engine: one access at a time, word-organised memory,
// read-modify-write for SB/SH, early rejection of bad accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64,
  parameter int AW        = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [2:0]    req_funct3,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic [1:0]    resp_err,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wr_data,
  input  logic [31:0]   mem_rd_data
);

  if (MEM_WORDS != (1 << AW)) begin : g_bad_cfg
    $error("load_store_unit: MEM_WORDS must equal 2**AW");
  end

  lsu_state_e    r_state;
  lsu_state_e    w_next;
  logic          r_we;
  logic [2:0]    r_funct3;
  logic [1:0]    r_err;
  logic [AW+1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_word;
  logic [1:0]    w_err;
  logic          w_accept;
  logic [31:0]   w_load;
  logic [31:0]   w_merge;

  assign w_err    = access_err(req_we, req_funct3, req_addr[1:0], |req_addr[31:AW+2]);
  assign w_accept = (r_state == IDLE) && req_valid;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_err != ERR_OK)                      w_next = RESP;
          else if (req_we && req_funct3 == F3_W)    w_next = WR;
          else                                      w_next = RD;
        end
      end
      RD:      w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_funct3 <= F3_B;
      r_err    <= ERR_OK;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we     <= req_we;
        r_funct3 <= req_funct3;
        r_err    <= w_err;
      end
    end
  end

  // Data registers carry no reset: every output they feed is gated by state.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_addr  <= req_addr[AW+1:0];
      r_wdata <= req_wdata;
    end
    if (r_state == RD) r_word <= mem_rd_data;
  end

  lsu_align u_align (
    .i_funct3 (r_funct3),
    .i_lane   (r_addr[1:0]),
    .i_word   (r_word),
    .i_wdata  (r_wdata),
    .o_load   (w_load),
    .o_merge  (w_merge)
  );

  assign req_ready   = (r_state == IDLE);
  assign mem_rd      = (r_state == RD);
  assign mem_wr      = (r_state == WR);
  assign mem_addr    = (mem_rd || mem_wr) ? r_addr[AW+1:2] : '0;
  assign mem_wr_data = mem_wr ? w_merge : '0;
  assign resp_valid  = (r_state == RESP);
  assign resp_err    = resp_valid ? r_err : ERR_OK;
  assign resp_rdata  = (resp_valid && !r_we && r_err == ERR_OK) ? w_load : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses against a byte-level reference memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int AW        = 6;
  localparam int MEM_WORDS = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic [1:0]    resp_err;
  logic          mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wr_data, mem_rd_data;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem     [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];

  typedef struct {
    logic [31:0]   rdata;
    logic [1:0]    err;
    logic [33:0]   after;
    int            lat_resp;
    int            lat_rd;
    int            lat_wr;
    int            n_resp;
    int            n_rd;
    int            n_wr;
    logic [31:0]   wr_word;
    logic [AW-1:0] idx;
  } obs_t;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_WORDS(MEM_WORDS), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
  );

  assign mem_rd_data = mem_rd ? mem[mem_addr] : 32'h0;
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wr_data;

  function automatic obs_t obs_zero();
    obs_t o;
    o.rdata = '0; o.err = '0; o.after = '0; o.lat_resp = 0; o.lat_rd = 0; o.lat_wr = 0;
    o.n_resp = 0; o.n_rd = 0; o.n_wr = 0; o.wr_word = '0; o.idx = '0;
    return o;
  endfunction

  // Reference: expected outcome from the ISA rules on a byte-addressed memory.
  task automatic ref_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output obs_t e);
    int size, lane, idx;
    logic legal;
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    e = obs_zero();
    e.n_resp = 1;
    legal = we ? (f3 <= 2) : (f3 <= 2 || f3 == 4 || f3 == 5);
    size  = (f3 == 0 || f3 == 4) ? 1 : (f3 == 1 || f3 == 5) ? 2 : 4;
    if (!legal)                      e.err = 2'd3;
    else if (addr % size != 0)       e.err = 2'd1;
    else if (addr >= MEM_WORDS * 4)  e.err = 2'd2;
    else                             e.err = 2'd0;
    if (e.err != 0) begin
      e.lat_resp = 1;
    end else begin
      idx = int'(addr / 4);
      lane = int'(addr % 4);
      w = ref_mem[idx];
      e.idx = AW'(idx);
      if (!we) begin
        e.lat_rd = 1; e.lat_resp = 2; e.n_rd = 1;
        b = 8'(w >> (lane * 8));
        h = 16'(w >> (lane * 8));
        case (f3)
          3'd0:    e.rdata = {{24{b[7]}}, b};
          3'd4:    e.rdata = {24'h0, b};
          3'd1:    e.rdata = {{16{h[15]}}, h};
          3'd5:    e.rdata = {16'h0, h};
          default: e.rdata = w;
        endcase
      end else begin
        for (int i = 0; i < size; i++) w[(lane + i) * 8 +: 8] = wd[i * 8 +: 8];
        ref_mem[idx] = w;
        e.wr_word = w;
        e.n_wr = 1;
        if (size == 4) begin
          e.lat_wr = 1; e.lat_resp = 2;
        end else begin
          e.lat_rd = 1; e.lat_wr = 2; e.lat_resp = 3; e.n_rd = 1;
        end
      end
    end
  endtask

  // Issues one request from IDLE and observes a bounded 6-cycle window after acceptance.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output obs_t o);
    o = obs_zero();
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_funct3 = 3'($urandom);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_rd) begin o.n_rd++; if (o.lat_rd == 0) begin o.lat_rd = k; o.idx = mem_addr; end end
      if (mem_wr) begin
        o.n_wr++;
        if (o.lat_wr == 0) begin o.lat_wr = k; o.wr_word = mem_wr_data; o.idx = mem_addr; end
      end
      if (o.lat_resp != 0 && k == o.lat_resp + 1) o.after = {resp_err, resp_rdata};
      if (resp_valid) begin
        o.n_resp++;
        if (o.lat_resp == 0) begin o.lat_resp = k; o.rdata = resp_rdata; o.err = resp_err; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wr_data} !== {1'b1, 75'b0}) begin
      n_errors++;
      $display("FAIL reset_outputs: got ready=%b rv=%b rd=%h err=%b mrd=%b mwr=%b ma=%h mwd=%h, want ready=1 and all else 0",
               req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wr_data);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_fill();
    obs_t o, e;
    logic [31:0] d;
    for (int i = 0; i < MEM_WORDS; i++) begin
      d = $urandom;
      ref_access(1'b1, F3_W, 32'(i * 4), d, e);
      run_access(1'b1, F3_W, 32'(i * 4), d, o);
      n_checks++;
      if (o.lat_wr !== 1 || o.wr_word !== d || o.idx !== AW'(i)) begin
        n_errors++;
        $display("FAIL fill_sw%0d: got lat_wr=%0d data=%h idx=%0d, want 1 %h %0d", i, o.lat_wr, o.wr_word, o.idx, d, i);
      end
      n_checks++;
      if (o.lat_resp !== 2 || o.err !== 2'b00 || o.n_rd !== 0) begin
        n_errors++;
        $display("FAIL fill_resp%0d: got lat=%0d err=%b n_rd=%0d, want 2 00 0", i, o.lat_resp, o.err, o.n_rd);
      end
    end
  endtask

  task automatic test_store_load();
    obs_t o, e;
    ref_access(1'b1, F3_W, 32'h08, 32'hDEADBEEF, e);
    run_access(1'b1, F3_W, 32'h08, 32'hDEADBEEF, o);
    n_checks++;
    if (o.lat_wr !== 1 || o.idx !== 6'd2 || o.wr_word !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL sw08_write: got lat=%0d idx=%0d data=%h, want 1 2 deadbeef", o.lat_wr, o.idx, o.wr_word);
    end
    n_checks++;
    if (o.lat_resp !== 2 || o.err !== 2'b00) begin
      n_errors++;
      $display("FAIL sw08_resp: got lat=%0d err=%b, want 2 00", o.lat_resp, o.err);
    end
    ref_access(1'b0, F3_W, 32'h08, 32'h0, e);
    run_access(1'b0, F3_W, 32'h08, 32'h0, o);
    n_checks++;
    if (o.lat_resp !== 2 || o.lat_rd !== 1 || o.rdata !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL lw08: got lat=%0d rd_lat=%0d data=%h, want 2 1 deadbeef", o.lat_resp, o.lat_rd, o.rdata);
    end
  endtask

  task automatic test_subword_store();
    obs_t o, e;
    ref_access(1'b1, F3_B, 32'h09, 32'h00000055, e);
    run_access(1'b1, F3_B, 32'h09, 32'h00000055, o);
    n_checks++;
    if (o.lat_rd !== 1 || o.lat_wr !== 2 || o.lat_resp !== 3 || o.wr_word !== 32'hDEAD55EF) begin
      n_errors++;
      $display("FAIL sb09: got rd=%0d wr=%0d resp=%0d data=%h, want 1 2 3 dead55ef", o.lat_rd, o.lat_wr, o.lat_resp, o.wr_word);
    end
    ref_access(1'b1, F3_H, 32'h0A, 32'h00001234, e);
    run_access(1'b1, F3_H, 32'h0A, 32'h00001234, o);
    n_checks++;
    if (o.lat_wr !== 2 || o.lat_resp !== 3 || o.wr_word !== 32'h123455EF || o.n_wr !== 1) begin
      n_errors++;
      $display("FAIL sh0a: got wr=%0d resp=%0d data=%h n_wr=%0d, want 2 3 123455ef 1", o.lat_wr, o.lat_resp, o.wr_word, o.n_wr);
    end
  endtask

  task automatic test_load_ext();
    obs_t o, e;
    logic [2:0]  f3s  [4] = '{F3_B, F3_BU, F3_H, F3_HU};
    logic [31:0] adrs [4] = '{32'h0B, 32'h0B, 32'h0A, 32'h08};
    logic [31:0] exps [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000BEEF};
    ref_access(1'b1, F3_W, 32'h08, 32'hDEADBEEF, e);
    run_access(1'b1, F3_W, 32'h08, 32'hDEADBEEF, o);
    for (int i = 0; i < 4; i++) begin
      ref_access(1'b0, f3s[i], adrs[i], 32'h0, e);
      run_access(1'b0, f3s[i], adrs[i], 32'h0, o);
      n_checks++;
      if (o.rdata !== exps[i] || o.err !== 2'b00 || o.lat_resp !== 2) begin
        n_errors++;
        $display("FAIL load_ext%0d: got data=%h err=%b lat=%0d, want %h 00 2", i, o.rdata, o.err, o.lat_resp, exps[i]);
      end
    end
  endtask

  task automatic test_errors();
    obs_t o;
    logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [2:0]  f3s  [5] = '{F3_W, F3_H, F3_W, 3'b011, 3'b011};
    logic [31:0] adrs [5] = '{32'h06, 32'h03, 32'h100, 32'h00, 32'h101};
    logic [1:0]  errs [5] = '{ERR_MISALIGN, ERR_MISALIGN, ERR_RANGE, ERR_ILLEGAL, ERR_ILLEGAL};
    for (int i = 0; i < 5; i++) begin
      run_access(wes[i], f3s[i], adrs[i], 32'hFFFFFFFF, o);
      n_checks++;
      if (o.err !== errs[i] || o.lat_resp !== 1 || o.n_resp !== 1) begin
        n_errors++;
        $display("FAIL err_case%0d: got err=%b lat=%0d n=%0d, want %b 1 1", i, o.err, o.lat_resp, o.n_resp, errs[i]);
      end
      n_checks++;
      if (o.n_rd !== 0 || o.n_wr !== 0 || o.rdata !== 32'h0) begin
        n_errors++;
        $display("FAIL err_mem%0d: got n_rd=%0d n_wr=%0d data=%h, want 0 0 0", i, o.n_rd, o.n_wr, o.rdata);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic we;
    logic [2:0] f3;
    logic [31:0] addr, wd;
    int sel;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom);
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
      else if (we) f3 = 3'($urandom_range(0, 2));
      else begin sel = $urandom_range(0, 4); f3 = (sel < 3) ? 3'(sel) : 3'(sel + 1); end
      addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 255));
      if ($urandom_range(0, 3) != 0) begin
        if (f3[1:0] == 2'd1) addr[0] = 1'b0;
        else if (f3[1:0] == 2'd2) addr[1:0] = 2'b00;
      end
      wd = $urandom;
      ref_access(we, f3, addr, wd, e);
      run_access(we, f3, addr, wd, o);
      n_checks++;
      if (o.err !== e.err || o.rdata !== e.rdata) begin
        n_errors++;
        $display("FAIL rnd%0d_resp we=%b f3=%0d a=%h: got err=%b data=%h, want %b %h", i, we, f3, addr, o.err, o.rdata, e.err, e.rdata);
      end
      n_checks++;
      if (o.lat_resp !== e.lat_resp || o.lat_rd !== e.lat_rd || o.lat_wr !== e.lat_wr) begin
        n_errors++;
        $display("FAIL rnd%0d_timing: got resp/rd/wr=%0d/%0d/%0d, want %0d/%0d/%0d", i, o.lat_resp, o.lat_rd, o.lat_wr, e.lat_resp, e.lat_rd, e.lat_wr);
      end
      n_checks++;
      if (o.n_resp !== 1 || o.n_rd !== e.n_rd || o.n_wr !== e.n_wr || o.after !== 34'h0) begin
        n_errors++;
        $display("FAIL rnd%0d_pulses: got resp=%0d rd=%0d wr=%0d after=%h, want 1 %0d %0d 0", i, o.n_resp, o.n_rd, o.n_wr, o.after, e.n_rd, e.n_wr);
      end
      n_checks++;
      if (o.wr_word !== e.wr_word || o.idx !== e.idx) begin
        n_errors++;
        $display("FAIL rnd%0d_mem: got word=%h idx=%0d, want %h %0d", i, o.wr_word, o.idx, e.wr_word, e.idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    obs_t o, e;
    logic saw;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h09; req_wdata = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n_checks++;
    if (mem_rd !== 1'b1) begin
      n_errors++;
      $display("FAIL midrst_in_rd: got mem_rd=%b, want 1", mem_rd);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({req_ready, resp_valid, resp_rdata, resp_err, mem_rd, mem_wr, mem_addr, mem_wr_data} !== {1'b1, 75'b0}) begin
      n_errors++;
      $display("FAIL midrst_outputs: got ready=%b rv=%b mrd=%b mwr=%b ma=%h mwd=%h, want 1 0 0 0 0 0",
               req_ready, resp_valid, mem_rd, mem_wr, mem_addr, mem_wr_data);
    end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); if (mem_wr || resp_valid) saw = 1'b1; end
    reset = 1'b0;
    repeat (4) begin @(negedge clk); if (mem_wr || resp_valid) saw = 1'b1; end
    n_checks++;
    if (saw !== 1'b0) begin
      n_errors++;
      $display("FAIL midrst_quiet: got mem_wr/resp_valid seen=%b, want 0", saw);
    end
    ref_access(1'b0, F3_W, 32'h08, 32'h0, e);
    run_access(1'b0, F3_W, 32'h08, 32'h0, o);
    n_checks++;
    if (o.rdata !== e.rdata || o.err !== 2'b00 || o.lat_resp !== 2) begin
      n_errors++;
      $display("FAIL midrst_after: got data=%h err=%b lat=%0d, want %h 00 2", o.rdata, o.err, o.lat_resp, e.rdata);
    end
  endtask

  task automatic test_back_to_back();
    obs_t e;
    logic [31:0] a;
    int acc, rsp, bad, rdy_bad;
    a = 32'($urandom_range(0, MEM_WORDS - 1) * 4);
    ref_access(1'b0, F3_W, a, 32'h0, e);
    acc = 0; rsp = 0; bad = 0; rdy_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = F3_W; req_addr = a;
    for (int k = 0; k < 30; k++) begin
      if (req_ready) acc++;
      if (req_ready !== !(mem_rd || resp_valid)) rdy_bad++;
      if (resp_valid) begin rsp++; if (resp_rdata !== e.rdata) bad++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (resp_valid) begin rsp++; if (resp_rdata !== e.rdata) bad++; end
      @(negedge clk);
    end
    n_checks++;
    if (acc !== 10 || rsp !== acc) begin
      n_errors++;
      $display("FAIL b2b_count: got accepts=%0d responses=%0d, want 10 10", acc, rsp);
    end
    n_checks++;
    if (bad !== 0 || rdy_bad !== 0) begin
      n_errors++;
      $display("FAIL b2b_data: got bad_data=%0d bad_ready=%0d, want 0 0", bad, rdy_bad);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    test_reset();
    test_fill();
    test_store_load();
    test_subword_store();
    test_load_ext();
    test_errors();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
